// File: rtl/mem_requester.sv
// Burst initiator for the unified instruction/data memory port: accepts one
// client request, issues it to memory and sequences 1/4/8/16 beats.
module mem_requester #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_rw,
   input  logic [1:0]        req_size,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [3:0]        rd_index,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic [1:0]        mem_access_size,
   output logic              mem_rw,
   output logic              mem_enable,
   input  logic              mem_busy,
   input  logic [DATA_W-1:0] mem_data_out
);

   typedef enum logic [2:0] {IDLE, ISSUE, RBURST, WBURST, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [1:0]        size_q;
   logic [3:0]        beat;
   logic              err_q;
   logic              accept;
   logic              active;

   function automatic logic [3:0] last_beat(input logic [1:0] size);
      case (size)
         2'b00:   return 4'd0;
         2'b01:   return 4'd3;
         2'b10:   return 4'd7;
         default: return 4'd15;
      endcase
   endfunction

   // Gating with reset keeps a request presented during reset from being taken.
   assign req_ready = (state == IDLE) && !mem_busy && !reset;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         beat  <= 4'd0;
         err_q <= 1'b0;
      end else begin
         err_q <= accept && (req_addr[1:0] != 2'b00);
         case (state)
            IDLE: begin
               if (accept && (req_addr[1:0] == 2'b00)) state <= ISSUE;
            end
            ISSUE: begin
               if (rw_q) begin
                  beat  <= 4'd1;
                  state <= (size_q == 2'b00) ? DONE : WBURST;
               end else begin
                  beat  <= 4'd0;
                  state <= RBURST;
               end
            end
            RBURST, WBURST: begin
               beat <= beat + 4'd1;
               if (beat == last_beat(size_q)) state <= DONE;
            end
            DONE: begin
               beat  <= 4'd0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request fields are pure data and need no reset; outputs are gated by state.
   always_ff @(posedge clock) begin
      if (accept) begin
         addr_q <= req_addr;
         rw_q   <= req_rw;
         size_q <= req_size;
      end
   end

   assign active          = (state != IDLE);
   assign mem_enable      = (state == ISSUE);
   assign mem_address     = active ? addr_q : '0;
   assign mem_rw          = active ? rw_q : 1'b0;
   assign mem_access_size = active ? size_q : 2'b00;
   assign wr_pop          = ((state == ISSUE) && rw_q) || (state == WBURST);
   assign mem_data_in     = wr_pop ? wr_data : '0;
   assign rd_valid        = (state == RBURST);
   assign rd_index        = rd_valid ? beat : 4'd0;
   assign rd_data         = rd_valid ? mem_data_out : '0;
   assign done            = (state == DONE);
   assign err             = err_q;

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester: table of transactions plus busy and
// mid-burst reset sequences, against a small burst memory model.
module tb_mem_requester;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_rw;
   logic [1:0]  req_size;
   logic [31:0] wr_data;
   logic        wr_pop;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [3:0]  rd_index;
   logic        done;
   logic        err;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [1:0]  mem_access_size;
   logic        mem_rw;
   logic        mem_enable;
   logic        mem_busy;
   logic [31:0] mem_data_out;

   int n_vec = 0;
   int n_bad = 0;

   mem_requester #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_rw(req_rw), .req_size(req_size),
      .wr_data(wr_data), .wr_pop(wr_pop),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index),
      .done(done), .err(err),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_access_size(mem_access_size), .mem_rw(mem_rw),
      .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
   endfunction

   function automatic int nbeats(input logic [1:0] s);
      case (s)
         2'b00:   return 1;
         2'b01:   return 4;
         2'b10:   return 8;
         default: return 16;
      endcase
   endfunction

   // Memory model: read beat k appears in the cycle E+1+k.
   logic        rd_active;
   logic [31:0] rd_base;
   logic [3:0]  rd_beat;
   logic [3:0]  rd_last;
   always @(posedge clock) begin
      if (reset) begin
         rd_active <= 1'b0;
      end else if (mem_enable && !mem_rw) begin
         rd_active <= 1'b1;
         rd_base   <= mem_address;
         rd_beat   <= 4'd0;
         rd_last   <= 4'(nbeats(mem_access_size) - 1);
      end else if (rd_active) begin
         if (rd_beat == rd_last) rd_active <= 1'b0;
         rd_beat <= rd_beat + 4'd1;
      end
   end
   assign mem_data_out = rd_active ? memword(rd_base + {26'd0, rd_beat, 2'b00}) : 32'h0;

   // Client write source: word k of a burst is 0x11*(k+1).
   logic [31:0] pop_cnt;
   always @(posedge clock) begin
      if (reset)       pop_cnt <= 32'd0;
      else if (wr_pop) pop_cnt <= mem_enable ? 32'd1 : pop_cnt + 32'd1;
   end
   assign wr_data = 32'h11 * ((mem_enable ? 32'd0 : pop_cnt) + 32'd1);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                          input int busy_cycles);
      int got, dones, ens, n;
      bit fin;
      n = nbeats(size);
      @(negedge clock);
      req_valid = 1'b1; req_addr = addr; req_rw = rw; req_size = size;
      for (int i = 0; i < busy_cycles; i++) begin
         mem_busy = 1'b1;
         #1;
         chk("busy_ready", req_ready, 0);
         chk("busy_enable", mem_enable, 0);
         @(negedge clock);
      end
      mem_busy = 1'b0;
      #1;
      chk("accept_ready", req_ready, 1);
      got = 0; dones = 0; ens = 0; fin = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clock);
         req_valid = 1'b0;
         if (c == 0) begin
            chk("issue_enable", mem_enable, 1);
            chk("issue_size", mem_access_size, size);
            chk("issue_ready", req_ready, 0);
         end
         chk("hold_addr", mem_address, addr);
         chk("hold_rw", mem_rw, rw);
         if (mem_enable) ens++;
         if (rd_valid) begin
            chk("rd_index", rd_index, got);
            chk("rd_data", rd_data, memword(addr + 32'(4 * got)));
            got++;
         end
         if (wr_pop) begin
            chk("wr_data", mem_data_in, 32'h11 * 32'(got + 1));
            got++;
         end
         if (done) begin
            dones++;
            chk("beats", got, n);
            chk("done_ready", req_ready, 0);
            fin = 1;
         end
      end
      if (!fin) chk("timeout_done", 0, 1);
      @(negedge clock);
      chk("done_once", done, 0);
      chk("idle_ready", req_ready, 1);
      chk("one_enable", ens, 1);
      chk("done_count", dones, 1);
   endtask

   task automatic run_err(input logic rw, input logic [31:0] addr);
      @(negedge clock);
      req_valid = 1'b1; req_addr = addr; req_rw = rw; req_size = 2'b01;
      #1;
      chk("err_accept_ready", req_ready, 1);
      @(negedge clock);
      req_valid = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_no_enable", mem_enable, 0);
      chk("err_ready", req_ready, 1);
      @(negedge clock);
      chk("err_clear", err, 0);
      chk("err_no_enable2", mem_enable, 0);
   endtask

   typedef struct {
      logic        rw;
      logic [1:0]  size;
      logic [31:0] addr;
      bit          misaligned;
   } vec_t;

   vec_t vecs[8];
   bit   hit;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 2'b00, 32'h0000_0100, 1'b0};
      vecs[1] = '{1'b0, 2'b11, 32'h0000_0200, 1'b0};
      vecs[2] = '{1'b1, 2'b01, 32'h0000_0040, 1'b0};
      vecs[3] = '{1'b0, 2'b01, 32'h0000_0080, 1'b0};
      vecs[4] = '{1'b1, 2'b10, 32'h0000_0300, 1'b0};
      vecs[5] = '{1'b1, 2'b00, 32'h0000_0010, 1'b0};
      vecs[6] = '{1'b0, 2'b00, 32'h0000_0102, 1'b1};
      vecs[7] = '{1'b1, 2'b11, 32'h0000_0203, 1'b1};

      reset = 1'b1; mem_busy = 1'b0;
      req_valid = 1'b1; req_addr = 32'h100; req_rw = 1'b0; req_size = 2'b00;
      repeat (3) @(negedge clock);
      chk("rst_ready", req_ready, 0);
      chk("rst_enable", mem_enable, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_wr_pop", wr_pop, 0);
      chk("rst_address", mem_address, 0);
      req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_no_capture", mem_enable, 0);
      @(negedge clock);
      chk("rst_no_capture2", mem_enable, 0);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].misaligned) run_err(vecs[i].rw, vecs[i].addr);
         else run_txn(vecs[i].rw, vecs[i].size, vecs[i].addr, 0);
      end

      run_txn(1'b0, 2'b00, 32'h0000_0100, 5);

      // Reset at read beat 3 of an 8-word burst.
      @(negedge clock);
      req_valid = 1'b1; req_addr = 32'h200; req_rw = 1'b0; req_size = 2'b10;
      @(negedge clock);
      req_valid = 1'b0;
      hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge clock);
         if (rd_valid && rd_index == 4'd3) hit = 1;
      end
      chk("reach_beat3", hit, 1);
      reset = 1'b1; mem_busy = 1'b1;
      @(negedge clock);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_enable", mem_enable, 0);
      chk("mid_rst_rd_valid", rd_valid, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_address", mem_address, 0);
      chk("mid_rst_size", mem_access_size, 0);
      reset = 1'b0; mem_busy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk("post_rst_no_done", done, 0);
         chk("post_rst_no_rd", rd_valid, 0);
      end
      run_txn(1'b0, 2'b00, 32'h0000_0100, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
